ext_pipe: RTL
=============

# ext_pipe

Parametrised, pipelined successor to the combinational immediate extender. Accepts an extension request (source word, mode, byte offset) over a valid/ready handshake, computes the extended DATA_W-bit result, and delivers it through a 2-entry output buffer with full throughput and back-pressure support. It sits between decode/MEM-return and the operand bus, where it serves both immediate extension and load-data byte/half extension.

## Interface
- IMM_W, 16: immediate field width, taken from src[IMM_W-1:0]; IMM_W >= 2.
- DATA_W, 32: result width; DATA_W must be a multiple of 8 and >= IMM_W+2.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- in_src  in  DATA_W  source word (immediate in low IMM_W bits, or load word).
- in_mode  in  3  extension mode (see Operation).
- in_off  in  2  byte offset for modes 100-111.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result this cycle.
- out_data  out  DATA_W  extended result.
- err  out  1  sticky error flag (present only with the macro below; otherwise tied 0).

## Operation
- Modes, where imm = in_src[IMM_W-1:0] and B/H = byte/half lane selected by in_off:
  - 000: sign-extend imm to DATA_W.
  - 001: zero-extend imm.
  - 010: imm placed in the top IMM_W bits, low DATA_W-IMM_W bits zero.
  - 011: sign-extend imm, then shift left 2 (branch offset); bits shifted past DATA_W-1 are dropped.
  - 100/101: B = in_src[8*in_off +: 8], sign-/zero-extended.
  - 110/111: H = in_src[16*in_off[1] +: 16], sign-/zero-extended.
- Lane select uses in_off modulo DATA_W/8; the offset is ignored in modes 000-011.
- Result is computed combinationally at acceptance and captured at the same edge. No arithmetic is carried beyond the DATA_W-bit truncation.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, skid slot empty, in_ready=1.
  - TWO: out_valid=1, skid slot full, in_ready=0.
- Transitions, with acc = in_valid&&in_ready and drn = out_valid&&out_ready:
  - EMPTY --acc--> ONE.
  - ONE --acc&&!drn--> TWO.
  - ONE --!acc&&drn--> EMPTY.
  - ONE --acc&&drn--> ONE, with the new result loaded into the output register.
  - TWO --drn--> ONE, with the skid entry moved to the output register.
  - TWO never accepts.
- Ordering is strict FIFO; a result is never dropped or duplicated.

## Timing
- Latency 1: a request accepted at edge N is visible on out_data with out_valid=1 after edge N, provided the buffer was EMPTY, or ONE with simultaneous drain.
- Throughput is 1 result per cycle while out_ready=1.
- in_ready is a registered-state decode (in_ready = state!=TWO), with no combinational path from out_ready.
- While out_valid=1 and out_ready=0, out_data is held stable.
- Reset (reset=0 at an edge) forces state EMPTY, out_valid=0, out_data=0, skid contents=0, and err=0, regardless of any in-flight handshake. in_ready=1 from the first cycle after reset.
- Inputs are don't-care when in_valid=0.

## Configuration
- EXT_PIPE_ALIGN_CHK_EN defined:
  - Mode 110/111 with in_off[0]=1 is misaligned.
  - The request is still accepted and produces out_data=0.
  - err is set at that edge and stays 1 until reset.
- Undefined:
  - No check; in_off[0] is ignored for half modes.
  - err is constant 0.

## Test plan
- Reset then idle: hold reset=0 two cycles -> out_valid=0, out_data=0, in_ready=1, err=0.
- Immediate modes, IMM_W=16/DATA_W=32, src=0x0000_8001, out_ready=1 -> modes 000..011 yield 0xFFFF8001, 0x00008001, 0x80010000, 0xFFFE0004, each 1 cycle after acceptance.
- Load lanes, src=0x80FF7F01 -> mode 100 off=1 gives 0x0000007F; 100 off=2 gives 0xFFFFFFFF; 101 off=3 gives 0x00000080; 110 off=2 gives 0xFFFF80FF; 111 off=0 gives 0x00007F01.
- Back-pressure: issue 3 back-to-back requests with out_ready=0 -> buffer accepts 2, then in_ready=0. Raise out_ready -> results emerge in order, one per cycle, then EMPTY.
- Reset mid-operation in state TWO -> next cycle out_valid=0, in_ready=1; the stale results never appear.
- With EXT_PIPE_ALIGN_CHK_EN: mode 110 off=1 -> out_data=0, err=1 and sticky through later valid requests. Without the macro, the same stimulus gives the off=0 half result and err=0.

Source files
------------

// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate / load-data extender with a 2-entry output buffer.
// Optional feature macro: EXT_PIPE_ALIGN_CHK_EN (misaligned half-word check, sticky err).
module ext_pipe #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src,
  input  logic [2:0]        in_mode,
  input  logic [1:0]        in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned PW = (DATA_W > 32) ? DATA_W : 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_out;
  logic [DATA_W-1:0]   r_skid;

  logic [IMM_W-1:0]    w_imm;
  logic [PW-1:0]       w_pad;
  logic [1:0]          w_boff;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_W-1:0]   w_sext;
  logic [DATA_W-1:0]   w_ext;
  logic                w_misalign;
  logic                w_acc;
  logic                w_drn;

  // Lane extraction; source is zero-padded so half lanes stay in range for narrow DATA_W
  assign w_imm  = in_src[IMM_W-1:0];
  assign w_pad  = PW'(in_src);
  assign w_boff = 2'(32'(in_off) % NB);
  assign w_byte = w_pad[{w_boff, 3'b000} +: 8];
  assign w_half = w_pad[{w_boff[1], 4'b0000} +: 16];
  assign w_sext = DATA_W'($signed(w_imm));

`ifdef EXT_PIPE_ALIGN_CHK_EN
  assign w_misalign = in_mode[2] & in_mode[1] & in_off[0];
`else
  assign w_misalign = 1'b0;
`endif

  // Extension result for the request presented this cycle
  always_comb begin
    w_ext = '0;
    case (in_mode)
      3'b000:  w_ext = w_sext;
      3'b001:  w_ext = DATA_W'(w_imm);
      3'b010:  w_ext = {w_imm, {(DATA_W-IMM_W){1'b0}}};
      3'b011:  w_ext = {w_sext[DATA_W-3:0], 2'b00};
      3'b100:  w_ext = DATA_W'($signed(w_byte));
      3'b101:  w_ext = DATA_W'(w_byte);
      3'b110:  w_ext = DATA_W'($signed(w_half));
      3'b111:  w_ext = DATA_W'(w_half);
      default: w_ext = '0;
    endcase
    if (w_misalign) w_ext = '0;
  end

  assign in_ready  = (r_state != ST_TWO);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_out;
  assign w_acc     = in_valid & in_ready;
  assign w_drn     = out_valid & out_ready;

  // Output register + skid slot; strict FIFO order, skid refills output on drain
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_out   <= w_ext;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && !w_drn) begin
            r_skid  <= w_ext;
            r_state <= ST_TWO;
          end else if (w_acc && w_drn) begin
            r_out   <= w_ext;
          end else if (w_drn) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drn) begin
            r_out   <= r_skid;
            r_state <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

`ifdef EXT_PIPE_ALIGN_CHK_EN
  logic r_err;

  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_acc && w_misalign) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
